// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the round-robin register write arbiter.
package reg_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int STAT_W = 16;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared register arbiter.
// Optional REG_ARB_STATS_EN adds the per-requester grant counters.
interface reg_write_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  import reg_arb_pkg::*;

  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         lock;
  logic [NREQ*WIDTH-1:0]   data;
  logic [NREQ-1:0]         gnt;
  logic [WIDTH-1:0]        out;
  logic [$clog2(NREQ)-1:0] owner;
  logic                    locked;
`ifdef REG_ARB_STATS_EN
  logic [NREQ*STAT_W-1:0]  grant_cnt;

  modport master (output req, lock, data, input gnt, out, owner, locked, grant_cnt);
  modport slave  (input req, lock, data, output gnt, out, owner, locked, grant_cnt);
`else
  modport master (output req, lock, data, input gnt, out, owner, locked);
  modport slave  (input req, lock, data, output gnt, out, owner, locked);
`endif

endinterface

// File: rtl/arb_register.sv
// WIDTH-bit storage register with write enable and synchronous clear.
module arb_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking, so every flop samples values from before the edge.
    if (reset)   q <= '0;
    else if (we) q <= d;
  end

endmodule

// File: rtl/rr_pick.sv
// Rotating-priority one-hot picker: first set request at or after ptr, wrapping mod N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int PW = $clog2(N);

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % N);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the loop, so no path can infer a latch.
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[wrap(int'(ptr) + k)]) begin
        any = 1'b1;
        idx = wrap(int'(ptr) + k);
        gnt[wrap(int'(ptr) + k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter with lockable ownership in front of one shared register.
// Define REG_ARB_STATS_EN to add 16-bit saturating per-requester grant counters.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int NREQ     = 4,
  parameter int MAX_LOCK = 8
) (
  input logic               clk,
  input logic               reset,
  reg_write_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (MAX_LOCK > 0) ? $clog2(MAX_LOCK + 1) : 8;

  arb_state_t     state;
  logic [PW-1:0]  ptr;
  logic [PW-1:0]  owner;
  logic [CW-1:0]  lock_cnt;

  logic [NREQ-1:0]  pick_gnt;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic [NREQ-1:0]  gnt;
  logic [PW-1:0]    win;
  logic             win_valid;
  logic [WIDTH-1:0] wdata;
  logic             at_limit;

  rr_pick #(.N(NREQ)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // While locked only the owner may write; reset suppresses every grant.
  always_comb begin
    gnt       = '0;
    win       = pick_idx;
    win_valid = 1'b0;
    if (!reset) begin
      if (state == ARB_LOCKED) begin
        win = owner;
        if (bus.req[owner]) begin
          gnt[owner] = 1'b1;
          win_valid  = 1'b1;
        end
      end else begin
        gnt       = pick_gnt;
        win_valid = pick_any;
      end
    end
  end

  always_comb begin
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) wdata = wdata | bus.data[i*WIDTH +: WIDTH];
    end
  end

  // lock_cnt counts grants already made in this lock; the grant bringing it to MAX_LOCK is the last.
  assign at_limit = (MAX_LOCK > 0) && (int'(lock_cnt) + 1 >= MAX_LOCK);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      if (win_valid) ptr <= PW'(rr_next(int'(win), NREQ));
      case (state)
        ARB_IDLE: begin
          if (win_valid && bus.lock[win] && MAX_LOCK != 1) begin
            state    <= ARB_LOCKED;
            owner    <= win;
            lock_cnt <= CW'(1);
          end
        end
        ARB_LOCKED: begin
          if (!win_valid || !bus.lock[owner] || at_limit) begin
            state    <= ARB_IDLE;
            lock_cnt <= '0;
          end else if (lock_cnt != '1) begin
            lock_cnt <= lock_cnt + CW'(1);
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  arb_register #(.WIDTH(WIDTH)) u_reg (
    .clk   (clk),
    .reset (reset),
    .we    (|gnt),
    .d     (wdata),
    .q     (bus.out)
  );

  assign bus.gnt    = gnt;
  assign bus.owner  = owner;
  assign bus.locked = (state == ARB_LOCKED);

`ifdef REG_ARB_STATS_EN
  logic [STAT_W-1:0] stat [NREQ];

  always_ff @(posedge clk) begin
    // NOTE: the counter array is explicitly cleared because counts must restart from zero after reset.
    if (reset) begin
      for (int i = 0; i < NREQ; i++) stat[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && stat[i] != '1) stat[i] <= stat[i] + STAT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign bus.grant_cnt[g*STAT_W +: STAT_W] = stat[g];
  end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: behavioural model compared every cycle plus directed literal checks.
module tb_reg_write_arbiter;

  localparam int WIDTH    = 32;
  localparam int NREQ     = 4;
  localparam int MAX_LOCK = 8;

  logic clk = 1'b0;
  logic reset;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  reg_write_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  reg_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the register, how many grants this lock has had, where the rotation resumes.
  int              m_ptr = 0;
  bit              m_locked = 1'b0;
  int              m_owner = 0;
  int              m_held = 0;
  logic [WIDTH-1:0] m_out = '0;
  int              m_gcnt [NREQ];
  int              e_win;
  logic [NREQ-1:0] e_gnt;

  always @(negedge clk) begin
    e_win = -1;
    if (!reset) begin
      if (m_locked) begin
        if (bus.req[m_owner]) e_win = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (e_win < 0 && bus.req[(m_ptr + k) % NREQ]) e_win = (m_ptr + k) % NREQ;
      end
    end
    e_gnt = '0;
    if (e_win >= 0) e_gnt[e_win] = 1'b1;

    if (chk_en) begin
      check("model_gnt", 64'(bus.gnt), 64'(e_gnt));
      check("model_out", 64'(bus.out), 64'(m_out));
      check("model_locked", 64'(bus.locked), 64'(m_locked));
      if (m_locked) check("model_owner", 64'(bus.owner), 64'(m_owner));
`ifdef REG_ARB_STATS_EN
      for (int i = 0; i < NREQ; i++)
        check("model_grant_cnt", 64'(bus.grant_cnt[i*16 +: 16]), 64'(m_gcnt[i]));
`endif
    end

    if (reset) begin
      m_ptr = 0; m_locked = 1'b0; m_owner = 0; m_held = 0; m_out = '0;
      for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
    end else begin
      if (e_win >= 0) begin
        m_out = bus.data[e_win*WIDTH +: WIDTH];
        m_ptr = (e_win + 1) % NREQ;
        if (m_gcnt[e_win] < 65535) m_gcnt[e_win] = m_gcnt[e_win] + 1;
      end
      if (m_locked) begin
        m_held = m_held + 1;
        if (e_win < 0 || !bus.lock[m_owner] || (MAX_LOCK > 0 && m_held >= MAX_LOCK)) begin
          m_locked = 1'b0;
          m_held   = 0;
        end
      end else if (e_win >= 0 && bus.lock[e_win] && MAX_LOCK != 1) begin
        m_locked = 1'b1;
        m_owner  = e_win;
        m_held   = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  logic [WIDTH-1:0] dval [NREQ];
  logic [NREQ-1:0]  one_hot;

  initial begin
    reset    = 1'b1;
    bus.req  = '0;
    bus.lock = '0;
    bus.data = '0;
    for (int i = 0; i < NREQ; i++) dval[i] = WIDTH'(32'h1111_1111 * (i + 1));
    step();
    chk_en = 1'b1;
    sample();
    check("reset_gnt", 64'(bus.gnt), 64'h0);
    check("reset_out", 64'(bus.out), 64'h0);
    step();
    reset = 1'b0;

    // Idle: nothing requested.
    repeat (5) begin
      sample();
      check("idle_gnt", 64'(bus.gnt), 64'h0);
      step();
    end
    check("idle_out", 64'(bus.out), 64'h0);
    check("idle_locked", 64'(bus.locked), 64'h0);

    // Plain round robin, all requesting.
    for (int i = 0; i < NREQ; i++) bus.data[i*WIDTH +: WIDTH] = dval[i];
    bus.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      sample();
      one_hot = 4'b0001 << (k % 4);
      check("rr_gnt", 64'(bus.gnt), 64'(one_hot));
      if (k > 0) check("rr_out", 64'(bus.out), 64'(dval[(k - 1) % 4]));
      step();
    end
    check("rr_out_last", 64'(bus.out), 64'(dval[3]));

    // Requester 1 locks, requester 2 waits.
    bus.data[1*WIDTH +: WIDTH] = 32'hA5;
    bus.req  = 4'b0110;
    bus.lock = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      sample();
      check("lock_gnt", 64'(bus.gnt), 64'b0010);
      if (k > 0) begin
        check("lock_locked", 64'(bus.locked), 64'h1);
        check("lock_owner", 64'(bus.owner), 64'h1);
      end
      step();
    end
    bus.lock = 4'b0000;
    sample();
    check("unlock_final_gnt", 64'(bus.gnt), 64'b0010);
    check("unlock_still_locked", 64'(bus.locked), 64'h1);
    step();
    sample();
    check("after_unlock_gnt", 64'(bus.gnt), 64'b0100);
    check("after_unlock_locked", 64'(bus.locked), 64'h0);
    check("after_unlock_out", 64'(bus.out), 64'hA5);
    step();
    bus.req = '0;

    // Timeout: requester 0 holds lock, requester 1 waits.
    bus.data[0*WIDTH +: WIDTH] = 32'h0BAD_F00D;
    bus.req  = 4'b0011;
    bus.lock = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      sample();
      check("timeout_gnt0", 64'(bus.gnt), 64'b0001);
      if (k > 0) check("timeout_locked", 64'(bus.locked), 64'h1);
      step();
    end
    sample();
    check("timeout_gnt1", 64'(bus.gnt), 64'b0010);
    check("timeout_released", 64'(bus.locked), 64'h0);
    step();
    bus.req  = '0;
    bus.lock = '0;
    sample();
    step();

    // Reset while locked.
    bus.data[0*WIDTH +: WIDTH] = 32'h1234;
    bus.req  = 4'b0001;
    bus.lock = 4'b0001;
    sample();
    step();
    sample();
    check("pre_reset_locked", 64'(bus.locked), 64'h1);
    check("pre_reset_out", 64'(bus.out), 64'h1234);
    step();
    reset    = 1'b1;
    bus.req  = 4'b0110;
    bus.lock = '0;
    sample();
    check("reset_cycle_gnt", 64'(bus.gnt), 64'h0);
    step();
    reset = 1'b0;
    sample();
    check("post_reset_out", 64'(bus.out), 64'h0);
    check("post_reset_locked", 64'(bus.locked), 64'h0);
    check("post_reset_gnt", 64'(bus.gnt), 64'b0010);
    step();
    bus.req = '0;

`ifdef REG_ARB_STATS_EN
    reset = 1'b1;
    step();
    reset   = 1'b0;
    bus.req = 4'b1111;
    repeat (40) step();
    for (int i = 0; i < NREQ; i++)
      check("stats_rr", 64'(bus.grant_cnt[i*16 +: 16]), 64'd10);
    bus.req = 4'b0001;
    repeat (70000) step();
    check("stats_sat", 64'(bus.grant_cnt[15:0]), 64'hFFFF);
    check("stats_other", 64'(bus.grant_cnt[31:16]), 64'd10);
    bus.req = '0;
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
